// File: rtl/layernorm_quant_top.sv
// layernorm_quant_top: quantized per-token LayerNorm engine.
//   Loads per-channel Scale/Bias once per run, then for each of Token_Nums
//   tokens collects Channel_Nums signed activations, derives mean, variance,
//   sd and 2^FRAC/sd with one shared sequential divider plus a restoring
//   square root, and streams Channel_Nums saturated int8 results.
// Ports:
//   clk, reset (async, active low), start (IDLE pulse)
//   Channel_Nums / Token_Nums        run geometry, sampled on start
//   sData_0 / sValid / sReady        activation stream in
//   Scale / Bias / ScaleBias_sValid / ScaleBias_sReady   gamma/beta stream in
//   mData_payload / mData_valid / mData_ready / mLast    int8 result stream out
// Build option: define LN_ROUND_EN for round-half-up before the FRAC shift;
//   without it the shift truncates toward -inf.
module layernorm_quant_top #(
    parameter int MAX_CH = 1023,
    parameter int IN_W   = 19,
    parameter int FRAC   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [9:0]      Channel_Nums,
    input  logic [19:0]     Token_Nums,
    input  logic [IN_W-1:0] sData_0,
    input  logic            sValid,
    output logic            sReady,
    input  logic            ScaleBias_sValid,
    output logic            ScaleBias_sReady,
    input  logic [7:0]      Scale,
    input  logic [7:0]      Bias,
    output logic            mData_valid,
    input  logic            mData_ready,
    output logic [7:0]      mData_payload,
    output logic            mLast
);
    localparam int SW = IN_W + 10;    // activation sum
    localparam int QW = 2*IN_W + 10;  // sum of squares; also divider dividend width
    localparam int MW = IN_W + 1;     // mean
    localparam int RW = QW / 2;       // sqrt root, also divisor width
    localparam int PW = 54;           // output product

    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_COLL = 3'd2, S_STATS = 3'd3, S_OUT = 3'd4;
    localparam logic [2:0] PH_INIT = 3'd0, PH_MEAN = 3'd1, PH_QDIV = 3'd2, PH_SQRT = 3'd3, PH_INV = 3'd4;

    localparam logic signed [PW-1:0] HALF = PW'(1) << (FRAC-1);
    localparam logic signed [PW-1:0] YMAX = 127;
    localparam logic signed [PW-1:0] YMIN = -128;

    logic [2:0]             r_state, r_phase;
    logic [5:0]             r_iter;
    logic [9:0]             r_n, r_cnt, r_oc, r_acc;
    logic [19:0]            r_t, r_tok;
    logic signed [SW-1:0]   r_S;
    logic [QW-1:0]          r_Q, r_dvd;
    logic signed [MW-1:0]   r_mean;
    logic [RW-1:0]          r_rem, r_dsr, r_root;
    logic [RW+1:0]          r_srem;
    logic [FRAC:0]          r_inv;
    logic                   r_mvalid, r_mlast;
    logic [7:0]             r_payload;

    // Buffers carry no reset: every entry read is written earlier in the run.
    logic [IN_W-1:0]        r_xbuf  [MAX_CH];
    logic [15:0]            r_sbbuf [MAX_CH];

    assign sReady           = (r_state == S_COLL);
    assign ScaleBias_sReady = (r_state == S_LOAD);
    assign mData_valid      = r_mvalid;
    assign mData_payload    = r_payload;
    assign mLast            = r_mlast;

    logic w_sfire, w_sbfire, w_mfire, w_issue;
    assign w_sfire  = sValid & sReady;
    assign w_sbfire = ScaleBias_sValid & ScaleBias_sReady;
    assign w_mfire  = r_mvalid & mData_ready;
    assign w_issue  = (r_state == S_OUT) && (r_oc < r_n) && (!r_mvalid || mData_ready);

    logic signed [SW-1:0]   w_xext;
    logic signed [2*IN_W-1:0] w_x, w_xsq;
    assign w_xext = {{(SW-IN_W){sData_0[IN_W-1]}}, sData_0};
    assign w_x    = {{IN_W{sData_0[IN_W-1]}}, sData_0};
    assign w_xsq  = w_x * w_x;

    // Restoring divider step: one quotient bit per cycle, shifted into r_dvd.
    logic [RW:0]   w_rsh;
    logic          w_dge;
    logic [RW-1:0] w_rnext;
    assign w_rsh   = {r_rem, r_dvd[QW-1]};
    assign w_dge   = w_rsh >= {1'b0, r_dsr};
    assign w_rnext = RW'(w_dge ? w_rsh - {1'b0, r_dsr} : w_rsh);

    // Restoring square-root step: two radicand bits in, one root bit out.
    logic [RW+3:0] w_srsh, w_trial;
    logic          w_sge;
    logic [RW+1:0] w_srnext;
    assign w_srsh   = {r_srem, r_dvd[QW-1 -: 2]};
    assign w_trial  = {2'b00, r_root, 2'b01};
    assign w_sge    = w_srsh >= w_trial;
    assign w_srnext = (RW+2)'(w_sge ? w_srsh - w_trial : w_srsh);

    // Floor division of a signed sum: divide the magnitude, then bump the
    // quotient away from zero when a negative sum leaves a remainder.
    logic [SW-1:0] w_sabs, w_mag;
    assign w_sabs = r_S[SW-1] ? (~r_S + SW'(1)) : r_S;
    assign w_mag  = r_dvd[SW-1:0] + SW'(r_S[SW-1] && (r_rem != '0));

    logic signed [2*MW-1:0] w_msq;
    logic signed [QW:0]     w_var_s;
    logic [QW-1:0]          w_var;
    logic [RW-1:0]          w_sd;
    assign w_msq   = r_mean * r_mean;
    assign w_var_s = $signed({1'b0, r_dvd}) - $signed({{(QW+1-2*MW){1'b0}}, w_msq});
    assign w_var   = w_var_s[QW] ? '0 : w_var_s[QW-1:0];
    assign w_sd    = (r_root == '0) ? RW'(1) : r_root;

    // Output datapath for channel r_oc.
    logic [IN_W-1:0]      w_xo;
    logic [15:0]          w_sbo;
    logic signed [MW:0]   w_diff;
    logic signed [PW-1:0] w_p, w_pr, w_y;
    logic [7:0]           w_sat;
    assign w_xo   = r_xbuf[r_oc];
    assign w_sbo  = r_sbbuf[r_oc];
    assign w_diff = $signed({w_xo[IN_W-1], w_xo[IN_W-1], w_xo}) - $signed({r_mean[MW-1], r_mean});
    assign w_p    = $signed({{(PW-MW-1){w_diff[MW]}}, w_diff})
                  * $signed({{(PW-8){w_sbo[15]}}, w_sbo[15:8]})
                  * $signed({{(PW-FRAC-1){1'b0}}, r_inv});
`ifdef LN_ROUND_EN
    assign w_pr   = w_p + HALF;
`else
    assign w_pr   = w_p;
`endif
    assign w_y    = (w_pr >>> FRAC) + $signed({{(PW-8){w_sbo[7]}}, w_sbo[7:0]});
    assign w_sat  = (w_y > YMAX) ? 8'h7f : (w_y < YMIN) ? 8'h80 : w_y[7:0];

    always_ff @(posedge clk) begin
        if (w_sbfire) r_sbbuf[r_cnt] <= {Scale, Bias};
        if (w_sfire)  r_xbuf[r_cnt]  <= sData_0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;  r_phase <= PH_INIT; r_iter <= '0;
            r_n <= '0; r_t <= '0; r_cnt <= '0; r_tok <= '0; r_oc <= '0; r_acc <= '0;
            r_S <= '0; r_Q <= '0; r_mean <= '0; r_dvd <= '0; r_rem <= '0; r_dsr <= '0;
            r_root <= '0; r_srem <= '0; r_inv <= '0;
            r_mvalid <= 1'b0; r_mlast <= 1'b0; r_payload <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_n <= Channel_Nums; r_t <= Token_Nums;
                    r_cnt <= '0; r_tok <= '0; r_S <= '0; r_Q <= '0;
                    r_state <= S_LOAD;
                end
                S_LOAD: if (w_sbfire) begin
                    if (r_cnt == r_n - 10'd1) begin r_cnt <= '0; r_state <= S_COLL; end
                    else r_cnt <= r_cnt + 10'd1;
                end
                S_COLL: if (w_sfire) begin
                    r_S <= r_S + w_xext;
                    r_Q <= r_Q + {{(QW-2*IN_W){1'b0}}, w_xsq};
                    if (r_cnt == r_n - 10'd1) begin
                        r_cnt <= '0; r_state <= S_STATS; r_phase <= PH_INIT; r_iter <= '0;
                    end else r_cnt <= r_cnt + 10'd1;
                end
                S_STATS: begin
                    if (r_iter != '0) begin
                        r_iter <= r_iter - 6'd1;
                        if (r_phase == PH_SQRT) begin
                            r_dvd  <= {r_dvd[QW-3:0], 2'b00};
                            r_srem <= w_srnext;
                            r_root <= {r_root[RW-2:0], w_sge};
                        end else begin
                            r_dvd <= {r_dvd[QW-2:0], w_dge};
                            r_rem <= w_rnext;
                        end
                    end else begin
                        case (r_phase)
                            PH_INIT: begin  // |S| left-aligned so only SW steps are needed
                                r_dvd <= {w_sabs, {(QW-SW){1'b0}}}; r_rem <= '0;
                                r_dsr <= {{(RW-10){1'b0}}, r_n}; r_iter <= 6'(SW); r_phase <= PH_MEAN;
                            end
                            PH_MEAN: begin
                                r_mean <= MW'(r_S[SW-1] ? (~w_mag + SW'(1)) : w_mag);
                                r_dvd <= r_Q; r_rem <= '0; r_iter <= 6'(QW); r_phase <= PH_QDIV;
                            end
                            PH_QDIV: begin
                                r_dvd <= w_var; r_srem <= '0; r_root <= '0;
                                r_iter <= 6'(RW); r_phase <= PH_SQRT;
                            end
                            PH_SQRT: begin  // dividend 2^FRAC: a single 1 followed by FRAC zeros
                                r_dvd <= {1'b1, {(QW-1){1'b0}}}; r_rem <= '0; r_dsr <= w_sd;
                                r_iter <= 6'(FRAC+1); r_phase <= PH_INV;
                            end
                            default: begin
                                r_inv <= r_dvd[FRAC:0];
                                r_oc <= '0; r_acc <= '0; r_state <= S_OUT;
                            end
                        endcase
                    end
                end
                S_OUT: begin
                    if (w_issue) begin
                        r_payload <= w_sat;
                        r_mlast   <= (r_oc == r_n - 10'd1) && (r_tok == r_t - 20'd1);
                        r_mvalid  <= 1'b1;
                        r_oc      <= r_oc + 10'd1;
                    end else if (w_mfire) begin
                        r_mvalid <= 1'b0;
                        r_mlast  <= 1'b0;
                    end
                    if (w_mfire) begin
                        if (r_acc == r_n - 10'd1) begin
                            r_acc <= '0; r_cnt <= '0; r_S <= '0; r_Q <= '0;
                            r_tok <= r_tok + 20'd1;
                            r_state <= (r_tok == r_t - 20'd1) ? S_IDLE : S_COLL;
                        end else r_acc <= r_acc + 10'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_layernorm_quant_top.sv
module tb_layernorm_quant_top;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  Channel_Nums = '0;
    logic [19:0] Token_Nums = '0;
    logic [18:0] sData_0 = '0;
    logic        sValid = 1'b0;
    logic        sReady;
    logic        ScaleBias_sValid = 1'b0;
    logic        ScaleBias_sReady;
    logic [7:0]  Scale = '0;
    logic [7:0]  Bias = '0;
    logic        mData_valid;
    logic        mData_ready = 1'b1;
    logic [7:0]  mData_payload;
    logic        mLast;

    int n_tests = 0;
    int n_fail  = 0;
    int xv[8];
    int ev[8];

    layernorm_quant_top dut (
        .clk(clk), .reset(reset), .start(start),
        .Channel_Nums(Channel_Nums), .Token_Nums(Token_Nums),
        .sData_0(sData_0), .sValid(sValid), .sReady(sReady),
        .ScaleBias_sValid(ScaleBias_sValid), .ScaleBias_sReady(ScaleBias_sReady),
        .Scale(Scale), .Bias(Bias),
        .mData_valid(mData_valid), .mData_ready(mData_ready),
        .mData_payload(mData_payload), .mLast(mLast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One full run: Scale/Bias offered continuously, activations xv[] repeated
    // per token, every accepted beat compared against ev[].
    task automatic run(input int n, input int t, input logic [7:0] sc, input logic [7:0] bs,
                       input bit tog, input bit burst);
        int sbc, xc, beats, lasts, cyc;
        logic [7:0] pp;
        logic pl;
        bit stall;
        sbc = 0; xc = 0; beats = 0; lasts = 0; cyc = 0; stall = 0; pp = '0; pl = 1'b0;
        @(negedge clk);
        Channel_Nums = 10'(n); Token_Nums = 20'(t); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("load_sb_ready", ScaleBias_sReady, 1);
        chk("load_s_ready", sReady, 0);
        while (beats < n*t && cyc < 20000) begin
            ScaleBias_sValid = 1'b1; Scale = sc; Bias = bs;
            sValid  = burst ? (cyc % 4 != 3) : 1'b1;
            sData_0 = 19'(xv[xc % n]);
            mData_ready = tog ? (cyc % 2 == 1) : 1'b1;
            if (stall) begin
                chk("hold_valid", mData_valid, 1);
                chk("hold_payload", $signed(mData_payload), $signed(pp));
                chk("hold_last", mLast, pl);
            end
            if (ScaleBias_sValid && ScaleBias_sReady) sbc++;
            if (sValid && sReady) xc++;
            if (mData_valid && mData_ready) begin
                chk("beat_value", $signed(mData_payload), ev[beats % n]);
                chk("beat_last", mLast, (beats == n*t-1));
                if (mLast) lasts++;
                beats++;
            end
            stall = mData_valid && !mData_ready;
            pp = mData_payload; pl = mLast;
            cyc++;
            @(negedge clk);
        end
        ScaleBias_sValid = 1'b0; sValid = 1'b0; mData_ready = 1'b1;
        chk("beat_count", beats, n*t);
        chk("last_count", lasts, 1);
        chk("sb_handshakes", sbc, n);
        chk("x_handshakes", xc, n*t);
        chk("idle_valid", mData_valid, 0);
        chk("idle_s_ready", sReady, 0);
        chk("idle_sb_ready", ScaleBias_sReady, 0);
    endtask

    initial begin
        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_s_ready", sReady, 0);
        chk("rst_sb_ready", ScaleBias_sReady, 0);
        chk("rst_valid", mData_valid, 0);
        chk("rst_last", mLast, 0);
        chk("rst_payload", mData_payload, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Out-of-phase offers in IDLE are refused
        sValid = 1'b1; ScaleBias_sValid = 1'b1;
        @(negedge clk);
        chk("idle_refuse_s", sReady, 0);
        chk("idle_refuse_sb", ScaleBias_sReady, 0);
        sValid = 1'b0; ScaleBias_sValid = 1'b0;

        // Reset mid-COLLECT
        @(negedge clk);
        Channel_Nums = 10'd4; Token_Nums = 20'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ScaleBias_sValid = 1'b1;
        repeat (4) @(negedge clk);
        ScaleBias_sValid = 1'b0;
        chk("mid_collect_ready", sReady, 1);
        sValid = 1'b1; sData_0 = 19'd5;
        @(negedge clk);
        sValid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_s_ready", sReady, 0);
        chk("midrst_sb_ready", ScaleBias_sReady, 0);
        chk("midrst_valid", mData_valid, 0);
        chk("midrst_last", mLast, 0);
        chk("midrst_payload", mData_payload, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", sReady, 0);
        chk("post_rst_sb_ready", ScaleBias_sReady, 0);

        // N=4, Scale=1, Bias=0, x={1,2,3,4}
        xv = '{1, 2, 3, 4, 0, 0, 0, 0};
        ev = '{-1, 0, 1, 2, 0, 0, 0, 0};
        run(4, 1, 8'd1, 8'd0, 1'b0, 1'b0);

        // Scale=64, Bias=10: last beat saturates from 138
        ev = '{-54, 10, 74, 127, 0, 0, 0, 0};
        run(4, 1, 8'd64, 8'd10, 1'b0, 1'b0);

        // Large spread: sd=100000 gives inv=0
        xv = '{-100000, 100000, 0, 0, 0, 0, 0, 0};
        ev = '{0, 0, 0, 0, 0, 0, 0, 0};
        run(2, 1, 8'd1, 8'd0, 1'b0, 1'b0);

        // Negative sum: mean floors to -2, var clamps to 0 -> sd=1
        xv = '{-3, 0, 0, 0, 0, 0, 0, 0};
        ev = '{-1, 2, 0, 0, 0, 0, 0, 0};
        run(2, 1, 8'd1, 8'd0, 1'b0, 1'b0);

        // sd=5, inv=13107, Scale=10, Bias=-3: fractional results
        xv = '{0, 10, 0, 0, 0, 0, 0, 0};
`ifdef LN_ROUND_EN
        ev = '{-13, 7, 0, 0, 0, 0, 0, 0};
`else
        ev = '{-13, 6, 0, 0, 0, 0, 0, 0};
`endif
        run(2, 1, 8'd10, 8'hfd, 1'b0, 1'b0);

        // Multi-token with output backpressure and bursty input
        xv = '{0, 0, 3, 0, 0, 0, 0, 0};
        ev = '{-1, -1, 2, 0, 0, 0, 0, 0};
        run(3, 3, 8'd1, 8'd0, 1'b1, 1'b1);

        // N=8, T=5, bursty input: mean=4, var=9, sd=3, inv=21845
        xv = '{1, 2, 3, 4, 5, 6, 7, 8};
`ifdef LN_ROUND_EN
        ev = '{-1, -1, 0, 0, 0, 1, 1, 1};
`else
        ev = '{-1, -1, -1, 0, 0, 0, 0, 1};
`endif
        run(8, 5, 8'd1, 8'd0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/layernorm_quant_top.md
Name: layernorm_quant_top

Overview:
- Quantized per-token LayerNorm engine for the transformer datapath.
- Flow: loads per-channel Scale/Bias once per run, then for each token collects Channel_Nums signed 19-bit activations.
- Per token it computes mean, variance and the reciprocal standard deviation, then streams Channel_Nums signed 8-bit normalized outputs.
- Sits between the upstream requantizer stream and the next int8 linear layer.

Parameters:
- MAX_CH, 1023: depth of the activation and Scale/Bias buffers; must be ≥ Channel_Nums.
- IN_W, 19: activation width, signed.
- FRAC, 16: fraction bits of the reciprocal standard deviation.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse in IDLE that begins a run.
- Channel_Nums  in  10  channels per token (N); sampled on start; 1..MAX_CH.
- Token_Nums  in  20  tokens per run (T); sampled on start; ≥1.
- sData_0  in  19  signed activation.
- sValid  in  1  activation valid.
- sReady  out  1  activation ready.
- ScaleBias_sValid  in  1  Scale/Bias valid.
- ScaleBias_sReady  out  1  Scale/Bias ready.
- Scale  in  8  signed per-channel gamma.
- Bias  in  8  signed per-channel beta.
- mData_valid  out  1  output valid.
- mData_ready  in  1  output ready.
- mData_payload  out  8  signed normalized result.
- mLast  out  1  high with the final output beat of the run.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; sReady=0, ScaleBias_sReady=0, mData_valid=0, mLast=0, mData_payload=0; all counters and accumulators cleared. The same applies if reset asserts mid-run.
- Handshake rule: a transfer occurs on a cycle when valid&ready are both high. A producer may hold valid while ready is low.
- Output holding: mData_payload and mLast stay stable while mData_valid=1 and mData_ready=0.
- IDLE: start=1 latches N and T, clears counters, and moves to LOAD_SB. start is ignored in every other state.
- LOAD_SB: ScaleBias_sReady=1. Each transfer writes {Scale,Bias} to channel index c = 0..N-1. After N transfers, go to COLLECT. sReady=0 in this state.
- COLLECT: sReady=1. Each transfer stores x to buf[c] and accumulates:
  - S += x (signed, 29-bit)
  - Q += x² (unsigned, 48-bit)
  - After N transfers, go to STATS.
- STATS: iterative, single shared sequential divider and restoring square root; ≤200 cycles; sReady=0.
  - mean = floor(S/N), using arithmetic floor.
  - var = floor(Q/N) − mean², clamped to ≥0.
  - sd = floor(sqrt(var)); if sd is 0, use sd=1.
  - inv = floor(2^FRAC / sd), 17-bit unsigned.
- OUTPUT: for c = 0..N-1:
  - p = (buf[c] − mean) × Scale[c] × inv, signed, at least 54 bits.
  - y = (p >>> FRAC) + Bias[c], using an arithmetic shift (truncation toward −inf) unless the optional feature is compiled in.
  - mData_payload = y saturated to [−128, 127].
  - One beat is presented per cycle while mData_ready=1; latency from STATS completion to the first mData_valid is ≤3 cycles.
  - After the Nth accepted beat: increment the token count. If it is < T, go to COLLECT (Scale/Bias are retained). Otherwise go to IDLE.
- mLast=1 only on beat c=N-1 of token T-1.
- Out-of-phase inputs: activations offered outside COLLECT and Scale/Bias offered outside LOAD_SB are not accepted (their ready is 0).

Optional Feature:
- Macro LN_ROUND_EN.
- Defined: y = ((p + 2^(FRAC-1)) >>> FRAC) + Bias[c], i.e. round half up, then saturate.
- Undefined: plain arithmetic-shift truncation as in Behaviour.
- Cost either way: one adder; no other change.

Test Plan:
- Reset mid-COLLECT (reset=0 for 2 cycles) -> all outputs 0, state IDLE. A new start then behaves normally.
- N=4, T=1; Scale=1, Bias=0 for all channels; x={1,2,3,4} -> mean=2, var=floor(30/4)−4=3, sd=1, inv=65536. Outputs {−1,0,1,2}; mLast on the 4th beat only.
- Same x with Scale=64, Bias=10 -> outputs {−54,10,74,127} (the last is saturated from 138).
- N=2, x={−100000,100000}, Scale=1 -> mean=0, sd=100000, inv=0. Outputs {0,0} without LN_ROUND_EN, and the same with it.
- N=768, T=197, sValid bursts of 32 cycles every 513, mData_ready=1 -> exactly 151296 output beats, one mLast. Scale/Bias are loaded once (768 ScaleBias handshakes).
- Output backpressure: mData_ready toggling every cycle -> payload stable while stalled; no beats lost or duplicated; counts match.
